// File: rtl/fir_tdm_mc.sv
// Multi-channel FIR filter sharing a single multiplier across all channels.
// Each accepted sample set is filtered by CH*TAPS sequential multiply-accumulate
// steps. The result is rounded half-up, shifted and saturated back to DW bits.
// Coefficients are double-buffered: writes go to a shadow bank, and the shadow
// bank is copied to the active bank only when the next sample set starts.
module fir_tdm_mc #(
   parameter int CH    = 2,
   parameter int TAPS  = 21,
   parameter int DW    = 16,
   parameter int CW    = 16,
   parameter int SHIFT = 15
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [CH*DW-1:0]         din,
   input  logic                     din_valid,
   input  logic                     bypass,
   input  logic                     coef_we,
   input  logic [$clog2(TAPS)-1:0]  coef_addr,
   input  logic [CW-1:0]            coef_data,
   input  logic                     coef_swap,
   input  logic                     ovr_clr,
   output logic [CH*DW-1:0]         dout,
   output logic                     dout_valid,
   output logic                     busy,
   output logic                     overrun
);

   localparam int TW  = $clog2(TAPS);
   localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
   localparam int PW  = DW + CW;
   localparam int AW  = PW + TW;
   localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;

   localparam logic signed [AW:0] RND  = (SHIFT > 0) ? ((AW+1)'(1) << RSH) : (AW+1)'(0);
   localparam logic signed [AW:0] SMAX = (AW+1)'({1'b0, {(DW-1){1'b1}}});
   localparam logic signed [AW:0] SMIN = ~SMAX;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MAC  = 2'd1,
      S_OUT  = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic signed [DW-1:0]   dl_q  [CH][TAPS];
   logic signed [CW-1:0]   shd_q [TAPS];
   logic signed [CW-1:0]   act_q [TAPS];
   logic signed [AW-1:0]   acc_q [CH];
   logic [TW-1:0]          tap_q;
   logic [CHW-1:0]         ch_q;
   logic                   pend_q;
   logic                   ovr_q;
   logic                   dvld_q;
   logic [CH*DW-1:0]       dout_q;

   logic                   accept;
   logic                   start;
   logic                   copy;
   logic                   last_mac;
   logic                   drop;
   logic signed [DW-1:0]   smp_sel;
   logic signed [CW-1:0]   cf_sel;
   logic signed [PW-1:0]   prod;

   // Round half up by adding half an LSB of the output, then arithmetic shift.
   function automatic logic signed [AW:0] rnd_shift(input logic signed [AW-1:0] a);
      logic signed [AW:0] t;
      t = (AW+1)'(a) + RND;
      return t >>> SHIFT;
   endfunction

   // Clamp the shifted accumulator into the DW-bit signed output range.
   function automatic logic signed [DW-1:0] sat(input logic signed [AW:0] v);
      if (v > SMAX) begin
         return DW'(SMAX);
      end else if (v < SMIN) begin
         return DW'(SMIN);
      end
      return DW'(v);
   endfunction

   assign accept   = (state_q == S_IDLE) && din_valid;
   assign start    = accept && !bypass;
   assign copy     = start && pend_q;
   assign drop     = din_valid && (state_q != S_IDLE);
   assign last_mac = (state_q == S_MAC) && (tap_q == TW'(TAPS - 1)) && (ch_q == CHW'(CH - 1));

   assign smp_sel  = dl_q[ch_q][tap_q];
   assign cf_sel   = act_q[tap_q];
   assign prod     = PW'(smp_sel) * PW'(cf_sel);

   assign dout       = dout_q;
   assign dout_valid = dvld_q;
   assign busy       = (state_q != S_IDLE);
   assign overrun    = ovr_q;

   // Sequencer next state: idle until a filtered sample set is accepted, then MAC, then one output cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_MAC;
         S_MAC:   if (last_mac) state_d = S_OUT;
         S_OUT:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Sequencer state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Per-channel delay lines; tap 0 holds the newest sample, bypassed samples shift in too.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < TAPS; k++) begin
               dl_q[c][k] <= '0;
            end
         end
      end else if (accept) begin
         for (int c = 0; c < CH; c++) begin
            dl_q[c][0] <= din[c*DW +: DW];
            for (int k = 1; k < TAPS; k++) begin
               dl_q[c][k] <= dl_q[c][k-1];
            end
         end
      end
   end

   // Shadow bank takes writes at any time; active bank reloads only when a new computation starts.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < TAPS; k++) begin
            shd_q[k] <= '0;
            act_q[k] <= '0;
         end
      end else begin
         if (coef_we && (32'(coef_addr) < TAPS)) begin
            shd_q[coef_addr] <= coef_data;
         end
         if (copy) begin
            for (int k = 0; k < TAPS; k++) begin
               act_q[k] <= shd_q[k];
            end
         end
      end
   end

   // Tap/channel walk: channel 0 taps 0..TAPS-1, then channel 1, and so on.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tap_q <= '0;
         ch_q  <= '0;
      end else if (start) begin
         tap_q <= '0;
         ch_q  <= '0;
      end else if (state_q == S_MAC) begin
         if (tap_q == TW'(TAPS - 1)) begin
            tap_q <= '0;
            ch_q  <= ch_q + 1'b1;
         end else begin
            tap_q <= tap_q + 1'b1;
         end
      end
   end

   // One multiply-accumulate per MAC cycle into the accumulator of the current channel.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int c = 0; c < CH; c++) begin
            acc_q[c] <= '0;
         end
      end else if (start) begin
         for (int c = 0; c < CH; c++) begin
            acc_q[c] <= '0;
         end
      end else if (state_q == S_MAC) begin
         acc_q[ch_q] <= acc_q[ch_q] + AW'(prod);
      end
   end

   // Output register: bypassed input or rounded/saturated results, with a one-cycle valid pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dout_q <= '0;
         dvld_q <= 1'b0;
      end else begin
         dvld_q <= 1'b0;
         if (accept && bypass) begin
            dout_q <= din;
            dvld_q <= 1'b1;
         end else if (state_q == S_OUT) begin
            for (int c = 0; c < CH; c++) begin
               dout_q[c*DW +: DW] <= sat(rnd_shift(acc_q[c]));
            end
            dvld_q <= 1'b1;
         end
      end
   end

   // Sticky overrun (a set wins over a clear) and the pending coefficient swap request.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovr_q  <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         ovr_q  <= drop || (ovr_q && !ovr_clr);
         pend_q <= (pend_q && !copy) || coef_swap;
      end
   end

endmodule
